// File: rtl/demux_sequencer.sv
// Upstream driver for the 1-to-4 demux: accepts a data word plus channel mask
// and walks the enabled channels in ascending order, holding each for DWELL cycles.
module demux_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] load_data,
  input  logic [3:0] load_mask,
  output logic       seq_in,
  output logic [1:0] seq_sel,
  output logic       seq_busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] data_q, data_nxt;
  logic [3:0] mask_q, mask_nxt;
  logic       ready_nxt, in_nxt, busy_nxt, done_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] first_sel, next_sel;
  logic       first_found, next_found;

  // Lowest enabled channel of the incoming word, and next enabled channel
  // above the one currently driven.
  always_comb begin
    first_sel   = '0;
    first_found = 1'b0;
    next_sel    = '0;
    next_found  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (load_mask[i] && !first_found) begin
        first_sel   = 2'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && (i > {30'd0, seq_sel}) && !next_found) begin
        next_sel   = 2'(i);
        next_found = 1'b1;
      end
    end
  end

  // Outputs are computed one cycle ahead so that every port comes straight from a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    mask_nxt  = mask_q;
    ready_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    sel_nxt   = '0;
    in_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (load_valid && load_ready) begin
          data_nxt  = load_data;
          mask_nxt  = load_mask;
          cnt_nxt   = '0;
          ready_nxt = 1'b0;
          if (first_found) begin
            state_nxt = DRIVE;
            busy_nxt  = 1'b1;
            sel_nxt   = first_sel;
            in_nxt    = load_data[first_sel];
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      DRIVE: begin
        busy_nxt = 1'b1;
        sel_nxt  = seq_sel;
        in_nxt   = seq_in;
        cnt_nxt  = cnt + 8'd1;
        if (cnt == DWELL_M1) begin
          cnt_nxt = '0;
          if (next_found) begin
            sel_nxt = next_sel;
            in_nxt  = data_q[next_sel];
          end else begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            sel_nxt   = '0;
            in_nxt    = 1'b0;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      load_ready <= 1'b1;
      seq_in     <= 1'b0;
      seq_sel    <= '0;
      seq_busy   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      data_q     <= data_nxt;
      mask_q     <= mask_nxt;
      load_ready <= ready_nxt;
      seq_in     <= in_nxt;
      seq_sel    <= sel_nxt;
      seq_busy   <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_demux_sequencer.sv
// Bench for demux_sequencer: three instances (DWELL 4, 2, 1) share stimulus and are
// compared every cycle against a per-frame expected-output schedule.
module tb_demux_sequencer;

  typedef logic [5:0] out_t;  // {ready, busy, done, sel[1:0], in}
  localparam out_t IDLE_V = 6'b100000;
  localparam out_t DONE_V = 6'b001000;
  localparam int unsigned DW [3] = '{4, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic [3:0] load_mask = '0;
  logic [2:0] rdy, busy, done, in_b;
  logic [1:0] sel [3];
  out_t       act [3];
  out_t       exp_v [3] = '{default: 6'b100000};
  out_t       sq [3][$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  demux_sequencer #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[0]),
    .load_data(load_data), .load_mask(load_mask), .seq_in(in_b[0]),
    .seq_sel(sel[0]), .seq_busy(busy[0]), .frame_done(done[0]));
  demux_sequencer #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[1]),
    .load_data(load_data), .load_mask(load_mask), .seq_in(in_b[1]),
    .seq_sel(sel[1]), .seq_busy(busy[1]), .frame_done(done[1]));
  demux_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy[2]),
    .load_data(load_data), .load_mask(load_mask), .seq_in(in_b[2]),
    .seq_sel(sel[2]), .seq_busy(busy[2]), .frame_done(done[2]));

  assign act[0] = {rdy[0], busy[0], done[0], sel[0], in_b[0]};
  assign act[1] = {rdy[1], busy[1], done[1], sel[1], in_b[1]};
  assign act[2] = {rdy[2], busy[2], done[2], sel[2], in_b[2]};

  // Reference: on an accepted word, queue the whole frame's per-cycle outputs
  // (DWELL entries per enabled channel, then one done cycle); idle when empty.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        sq[d].delete();
        exp_v[d] <= IDLE_V;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (sq[d].size() == 0 && exp_v[d][5] && load_valid) begin
          for (int ch = 0; ch < 4; ch++)
            if (load_mask[ch])
              repeat (DW[d]) sq[d].push_back({3'b010, 2'(ch), load_data[ch]});
          sq[d].push_back(DONE_V);
        end
        if (sq[d].size() != 0) exp_v[d] <= sq[d].pop_front();
        else exp_v[d] <= IDLE_V;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    load_valid = 1'b1;
    load_mask = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== IDLE_V) begin
          bad++;
          $display("FAIL reset dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], IDLE_V);
        end
      end
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL idle dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic drain(input int n);
    load_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL drain dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int done_cyc = -1;
    int ready_cyc = -1;
    load_valid = 1'b1;
    load_data = 4'b1010;
    load_mask = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) load_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL full_frame dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
      if (done[0] === 1'b1 && done_cyc < 0) done_cyc = c;
      if (rdy[0] === 1'b1 && ready_cyc < 0) ready_cyc = c;
    end
    total++;
    if (done_cyc != 17) begin
      bad++;
      $display("FAIL full_frame_done_cycle got=%0d exp=17", done_cyc);
    end
    total++;
    if (ready_cyc != 18) begin
      bad++;
      $display("FAIL full_frame_ready_cycle got=%0d exp=18", ready_cyc);
    end
  endtask

  task automatic test_sparse();
    int done_cyc = -1;
    int skipped = 0;
    load_valid = 1'b1;
    load_data = 4'b1111;
    load_mask = 4'b1001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) load_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL sparse dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
      if (done[1] === 1'b1 && done_cyc < 0) done_cyc = c;
      if (busy[1] === 1'b1 && (sel[1] == 2'd1 || sel[1] == 2'd2)) skipped++;
    end
    total++;
    if (done_cyc != 5) begin
      bad++;
      $display("FAIL sparse_done_cycle got=%0d exp=5", done_cyc);
    end
    total++;
    if (skipped != 0) begin
      bad++;
      $display("FAIL sparse_skip got=%0d selections of ch1/ch2 exp=0", skipped);
    end
  endtask

  task automatic test_empty();
    int busy_seen = 0;
    load_valid = 1'b1;
    load_data = 4'b1111;
    load_mask = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) load_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL empty dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
        if (busy[d] !== 1'b0) busy_seen++;
      end
      total++;
      if (c == 1 && done !== 3'b111) begin
        bad++;
        $display("FAIL empty_done cyc=1 got=%b exp=111", done);
      end else if (c == 2 && rdy !== 3'b111) begin
        bad++;
        $display("FAIL empty_ready cyc=2 got=%b exp=111", rdy);
      end
    end
    total++;
    if (busy_seen != 0) begin
      bad++;
      $display("FAIL empty_busy got=%0d busy cycles exp=0", busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    load_valid = 1'b1;
    load_mask = 4'b1011;
    for (int c = 0; c < 80; c++) begin
      load_data = 4'($urandom);
      if (c % 10 == 9) load_mask = 4'($urandom);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL back_to_back dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    int done_cyc = -1;
    load_valid = 1'b1;
    load_data = 4'b1010;
    load_mask = 4'b1111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) load_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL mid_pre dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (act[d] !== IDLE_V) begin
        bad++;
        $display("FAIL mid_async dut%0d got=%b exp=%b", d, act[d], IDLE_V);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL mid_post dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
      if (done !== 3'b000) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d done cycles exp=0", done_seen);
    end
    load_valid = 1'b1;
    load_data = 4'b0110;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) load_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL mid_reload dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
      if (done[0] === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    total++;
    if (done_cyc != 17) begin
      bad++;
      $display("FAIL mid_reload_done_cycle got=%0d exp=17", done_cyc);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data = 4'($urandom);
      load_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act[d] !== exp_v[d]) begin
          bad++;
          $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", d, c, act[d], exp_v[d]);
        end
      end
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    drain(20);
    test_sparse();
    drain(20);
    test_empty();
    drain(20);
    test_back_to_back();
    drain(40);
    test_reset_mid();
    drain(20);
    test_random();
    drain(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
